// File: rtl/i_decode_if.sv
// Fetch-to-decode bus: instruction/pc in, decoded fields and control flags out.
interface i_decode_if;
  logic [31:0] instrIn;
  logic [31:0] pcIn;
  logic        stallIn;
  logic        flush;
  logic        valid;
  logic [31:0] pcOut;
  logic [1:0]  opClass;
  logic [3:0]  subOp;
  logic        setFlags;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] imm32;
  logic        regWrite;
  logic        isLoad;
  logic        isStore;
  logic        isBranch;
  logic        stallOut;

  modport master (
    output instrIn, pcIn, stallIn, flush,
    input  valid, pcOut, opClass, subOp, setFlags, rd, rs1, rs2, imm32,
           regWrite, isLoad, isStore, isBranch, stallOut
  );

  modport slave (
    input  instrIn, pcIn, stallIn, flush,
    output valid, pcOut, opClass, subOp, setFlags, rd, rs1, rs2, imm32,
           regWrite, isLoad, isStore, isBranch, stallOut
  );
endinterface

// File: rtl/i_decode.sv
// Decode stage: registers decoded fields one cycle after fetch and inserts a
// single bubble on a load-use hazard.
//   state     | meaning
//   S_RUN     | normal capture; load-use hazard detection active
//   S_HAZARD  | bubble issued; capture the instruction fetch held for us
module i_decode (
  input  logic        clk,
  input  logic        rst,
  i_decode_if.slave   bus
);

  typedef enum logic {S_RUN, S_HAZARD} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cls_q, cls_d;
  logic [3:0]  sub_q, sub_d;
  logic        setf_q, setf_d;
  logic [3:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        regw_q, regw_d, ld_q, ld_d, st_q, st_d, br_q, br_d;

  logic [1:0]  cls;
  logic [3:0]  sub, rd, rs1, rs2;
  logic        dec_valid, dec_regw, dec_ld, dec_st, dec_br;
  logic        use_rs1, use_rs2, use_rd;
  logic [31:0] dec_imm;
  logic        hazard;

  assign cls = bus.instrIn[31:30];
  assign sub = bus.instrIn[28:25];
  assign rd  = bus.instrIn[24:21];
  assign rs1 = bus.instrIn[20:17];
  assign rs2 = bus.instrIn[16:13];

  always_comb begin
    dec_valid = 1'b0;
    dec_regw  = 1'b0;
    dec_ld    = 1'b0;
    dec_st    = 1'b0;
    dec_br    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    dec_imm   = {{16{bus.instrIn[15]}}, bus.instrIn[15:0]};
    unique case (cls)
      2'b00: begin
        dec_valid = 1'b1;
        dec_regw  = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      2'b01: begin
        dec_valid = 1'b1;
        dec_regw  = 1'b1;
        use_rs1   = 1'b1;
        if (sub[3]) dec_imm = {16'h0000, bus.instrIn[15:0]};
      end
      2'b10: begin
        if (sub == 4'b0000) begin
          dec_valid = 1'b1;
          dec_ld    = 1'b1;
          dec_regw  = 1'b1;
          use_rs1   = 1'b1;
        end else if (sub == 4'b0001) begin
          dec_valid = 1'b1;
          dec_st    = 1'b1;
          use_rs1   = 1'b1;
          use_rd    = 1'b1;
        end
      end
      default: begin
        // Unconditional B was already taken by fetch, so it decodes as a bubble
        if (sub == 4'b0010) begin
          dec_valid = 1'b1;
        end else if (sub == 4'b0001) begin
          dec_valid = 1'b1;
          dec_br    = 1'b1;
          use_rs1   = 1'b1;
        end
      end
    endcase
  end

  assign hazard = (state_q == S_RUN) && valid_q && ld_q && (rd_q != 4'd0) &&
                  ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q) ||
                   (use_rd && rd == rd_q));

  assign bus.stallOut = bus.stallIn | hazard;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    cls_d   = cls_q;
    sub_d   = sub_q;
    setf_d  = setf_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    regw_d  = regw_q;
    ld_d    = ld_q;
    st_d    = st_q;
    br_d    = br_q;
    if (bus.flush) begin
      state_d = S_RUN;
      valid_d = 1'b0;
      regw_d  = 1'b0;
      ld_d    = 1'b0;
      st_d    = 1'b0;
      br_d    = 1'b0;
    end else if (!bus.stallIn) begin
      if (hazard) begin
        state_d = S_HAZARD;
        valid_d = 1'b0;
        regw_d  = 1'b0;
        ld_d    = 1'b0;
        st_d    = 1'b0;
        br_d    = 1'b0;
      end else begin
        state_d = S_RUN;
        valid_d = dec_valid;
        pc_d    = bus.pcIn;
        cls_d   = cls;
        sub_d   = sub;
        setf_d  = bus.instrIn[29];
        rd_d    = rd;
        rs1_d   = rs1;
        rs2_d   = rs2;
        imm_d   = dec_imm;
        regw_d  = dec_regw;
        ld_d    = dec_ld;
        st_d    = dec_st;
        br_d    = dec_br;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cls_q   <= '0;
      sub_q   <= '0;
      setf_q  <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      regw_q  <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cls_q   <= cls_d;
      sub_q   <= sub_d;
      setf_q  <= setf_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      regw_q  <= regw_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      br_q    <= br_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.pcOut    = pc_q;
  assign bus.opClass  = cls_q;
  assign bus.subOp    = sub_q;
  assign bus.setFlags = setf_q;
  assign bus.rd       = rd_q;
  assign bus.rs1      = rs1_q;
  assign bus.rs2      = rs2_q;
  assign bus.imm32    = imm_q;
  assign bus.regWrite = regw_q;
  assign bus.isLoad   = ld_q;
  assign bus.isStore  = st_q;
  assign bus.isBranch = br_q;

endmodule

// File: tb/tb_i_decode.sv
// Directed-vector bench for i_decode with hand-computed expectations.
module tb_i_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  i_decode_if bus ();

  i_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.instrIn = instr;
    bus.pcIn    = pc;
  endtask

  initial begin
    bus.instrIn = '0;
    bus.pcIn    = '0;
    bus.stallIn = 1'b0;
    bus.flush   = 1'b0;
    rst = 1'b1;
    cyc();
    drive(32'h4A21_FFFC, 32'h10);
    cyc();
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_pc", bus.pcOut, 32'h0);
    chk("rst_imm", bus.imm32, 32'h0);
    chk("rst_regw", 32'(bus.regWrite), 32'd0);
    chk("rst_stall", 32'(bus.stallOut), 32'd0);

    // ALU-imm, first capture after reset release
    rst = 1'b0;
    cyc();
    chk("aluimm_valid", 32'(bus.valid), 32'd1);
    chk("aluimm_regw", 32'(bus.regWrite), 32'd1);
    chk("aluimm_imm", bus.imm32, 32'hFFFF_FFFC);
    chk("aluimm_pc", bus.pcOut, 32'h10);
    chk("aluimm_rd", 32'(bus.rd), 32'd1);
    chk("aluimm_cls", 32'(bus.opClass), 32'd1);
    chk("aluimm_sub", 32'(bus.subOp), 32'd5);

    // Load r3, then ALU-reg reading r3
    drive(32'h806A_0008, 32'h20);
    cyc();
    chk("ld_valid", 32'(bus.valid), 32'd1);
    chk("ld_isload", 32'(bus.isLoad), 32'd1);
    chk("ld_regw", 32'(bus.regWrite), 32'd1);
    chk("ld_rd", 32'(bus.rd), 32'd3);
    chk("ld_imm", bus.imm32, 32'h8);
    drive(32'h0286_4000, 32'h24);
    #1;
    chk("lu_stallout", 32'(bus.stallOut), 32'd1);
    cyc();
    chk("lu_bubble", 32'(bus.valid), 32'd0);
    chk("lu_stall_clr", 32'(bus.stallOut), 32'd0);
    cyc();
    chk("lu_valid", 32'(bus.valid), 32'd1);
    chk("lu_pc", bus.pcOut, 32'h24);
    chk("lu_rd", 32'(bus.rd), 32'd4);
    chk("lu_rs1", 32'(bus.rs1), 32'd3);
    chk("lu_rs2", 32'(bus.rs2), 32'd2);
    chk("lu_isload", 32'(bus.isLoad), 32'd0);

    // Load r0, then use r0: no hazard
    drive(32'h8002_0000, 32'h30);
    cyc();
    chk("ld0_isload", 32'(bus.isLoad), 32'd1);
    drive(32'h00A0_0000, 32'h34);
    #1;
    chk("r0_stallout", 32'(bus.stallOut), 32'd0);
    cyc();
    chk("r0_valid", 32'(bus.valid), 32'd1);
    chk("r0_pc", bus.pcOut, 32'h34);

    // Load r6, then store whose data register is r6
    drive(32'h80C2_0000, 32'h40);
    cyc();
    drive(32'h82CE_0000, 32'h44);
    #1;
    chk("st_stallout", 32'(bus.stallOut), 32'd1);
    cyc();
    chk("st_bubble", 32'(bus.valid), 32'd0);
    cyc();
    chk("st_valid", 32'(bus.valid), 32'd1);
    chk("st_isstore", 32'(bus.isStore), 32'd1);
    chk("st_regw", 32'(bus.regWrite), 32'd0);
    chk("st_pc", bus.pcOut, 32'h44);

    // Logical ALU-imm zero-extends, then a 3-cycle downstream stall
    drive(32'h5042_8001, 32'h50);
    cyc();
    chk("zext_imm", bus.imm32, 32'h0000_8001);
    chk("zext_pc", bus.pcOut, 32'h50);
    drive(32'hC400_0000, 32'h54);
    bus.stallIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_out%0d", i), 32'(bus.stallOut), 32'd1);
      cyc();
      chk($sformatf("stall_pc%0d", i), bus.pcOut, 32'h50);
      chk($sformatf("stall_imm%0d", i), bus.imm32, 32'h0000_8001);
    end
    bus.stallIn = 1'b0;
    cyc();
    chk("nop_valid", 32'(bus.valid), 32'd1);
    chk("nop_regw", 32'(bus.regWrite), 32'd0);
    chk("nop_pc", bus.pcOut, 32'h54);
    drive(32'hC000_0004, 32'h58);
    cyc();
    chk("b_valid", 32'(bus.valid), 32'd0);
    drive(32'hC200_FFF0, 32'h5C);
    cyc();
    chk("bcc_valid", 32'(bus.valid), 32'd1);
    chk("bcc_isbranch", 32'(bus.isBranch), 32'd1);
    chk("bcc_imm", bus.imm32, 32'hFFFF_FFF0);
    drive(32'h8400_0000, 32'h60);
    cyc();
    chk("badmem_valid", 32'(bus.valid), 32'd0);

    // flush + stallIn together on a load
    drive(32'h806A_0008, 32'h64);
    bus.flush   = 1'b1;
    bus.stallIn = 1'b1;
    cyc();
    chk("flush_valid", 32'(bus.valid), 32'd0);
    chk("flush_isload", 32'(bus.isLoad), 32'd0);
    bus.flush   = 1'b0;
    bus.stallIn = 1'b0;

    // Enter S_HAZARD (proves flush left us in S_RUN), then reset there
    drive(32'h806A_0008, 32'h70);
    cyc();
    drive(32'h0286_4000, 32'h74);
    #1;
    chk("post_flush_haz", 32'(bus.stallOut), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rsthz_valid", 32'(bus.valid), 32'd0);
    chk("rsthz_pc", bus.pcOut, 32'h0);
    chk("rsthz_imm", bus.imm32, 32'h0);
    chk("rsthz_rd", 32'(bus.rd), 32'd0);
    chk("rsthz_stall", 32'(bus.stallOut), 32'd0);
    rst = 1'b0;
    cyc();
    chk("rsthz_cap_valid", 32'(bus.valid), 32'd1);
    chk("rsthz_cap_pc", bus.pcOut, 32'h74);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
